// File: rtl/maze_run_if.sv
// Bus bundle for the Labyrinth run-sequencing controller.
// The master side issues the control pulses and observes the run status.
// The slave side is the controller itself.
interface maze_run_if;
    logic        start;
    logic        pause;
    logic        goal;
    logic        clear_best;
    logic [1:0]  state;
    logic [15:0] elapsed;
    logic [15:0] last_time;
    logic [15:0] best_time;
    logic        best_valid;
    logic        new_record;
    logic        timed_out;

    modport master (
        output start, pause, goal, clear_best,
        input  state, elapsed, last_time, best_time, best_valid, new_record, timed_out
    );

    modport slave (
        input  start, pause, goal, clear_best,
        output state, elapsed, last_time, best_time, best_valid, new_record, timed_out
    );
endinterface

// File: rtl/maze_run_ctrl.sv
// Labyrinth maze timer run controller.
// Owns the run state machine (IDLE/RUNNING/PAUSED/FINISHED), a time base
// that only advances while RUNNING, the elapsed run time in 1/TICK_RATE s
// steps, the final time of the last run and the session best time.
// Optional feature macro: MAZE_TIMEOUT_EN -- when defined, a run that
// reaches TIME_LIMIT finishes on its own and flags timed_out.
module maze_run_ctrl #(
    parameter int CLK_FREQ   = 100000000,
    parameter int TICK_RATE  = 10,
    parameter int TIME_LIMIT = 3000
) (
    input  logic       clk,
    input  logic       reset_n,
    maze_run_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        PAUSED   = 2'd2,
        FINISHED = 2'd3
    } state_t;

    localparam int DIV_N = CLK_FREQ / TICK_RATE;
    localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [DIV_W-1:0] TICK_HIT = DIV_W'(DIV_N - 1);

`ifdef MAZE_TIMEOUT_EN
    localparam logic [15:0] LIMIT    = 16'(TIME_LIMIT);
    localparam logic [15:0] LIMIT_M1 = 16'(TIME_LIMIT - 1);
`endif

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      elapsed_q, elapsed_d;
    logic [15:0]      last_q, last_d;
    logic [15:0]      best_q, best_d;
    logic             valid_q, valid_d;
    logic             rec_q, rec_d;
    logic             tick;
`ifdef MAZE_TIMEOUT_EN
    logic             to_q, to_d;
`endif

    // Elapsed time never wraps: it sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // State register: async reset back to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, time base, elapsed and record bookkeeping.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        elapsed_d = elapsed_q;
        last_d    = last_q;
        best_d    = best_q;
        valid_d   = valid_q;
        rec_d     = 1'b0;
`ifdef MAZE_TIMEOUT_EN
        to_d      = to_q;
`endif
        tick = (state_q == RUNNING) && (div_q == TICK_HIT);

        case (state_q)
            IDLE, FINISHED: begin
                // start beats a simultaneous pause; goal is meaningless here
                if (bus.start) begin
                    state_d   = RUNNING;
                    elapsed_d = 16'd0;
                    div_d     = '0;
                end
            end
            RUNNING: begin
                // divider keeps its phase; the tick it produces may be discarded below
                div_d = tick ? '0 : div_q + 1'b1;
                if (bus.goal) begin
                    state_d = FINISHED;
                    last_d  = elapsed_q;
`ifdef MAZE_TIMEOUT_EN
                    to_d    = 1'b0;
`endif
                    // strictly faster only: an equal time is not a record
                    if (!valid_q || (elapsed_q < best_q)) begin
                        best_d  = elapsed_q;
                        valid_d = 1'b1;
                        rec_d   = 1'b1;
                    end
                end else if (bus.pause) begin
                    state_d = PAUSED;
                end else if (tick) begin
`ifdef MAZE_TIMEOUT_EN
                    if (elapsed_q >= LIMIT_M1) begin
                        elapsed_d = LIMIT;
                        last_d    = LIMIT;
                        to_d      = 1'b1;
                        state_d   = FINISHED;
                    end else begin
                        elapsed_d = sat_inc(elapsed_q);
                    end
`else
                    elapsed_d = sat_inc(elapsed_q);
`endif
                end
            end
            PAUSED: begin
                // resume continues the same divider phase
                if (bus.pause) begin
                    state_d = RUNNING;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // forgetting the best overrides any record taken this cycle
        if (bus.clear_best) begin
            best_d  = 16'hFFFF;
            valid_d = 1'b0;
            rec_d   = 1'b0;
        end
    end

    // Datapath registers: all return to their reset values asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= '0;
            elapsed_q <= 16'd0;
            last_q    <= 16'd0;
            best_q    <= 16'hFFFF;
            valid_q   <= 1'b0;
            rec_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            elapsed_q <= elapsed_d;
            last_q    <= last_d;
            best_q    <= best_d;
            valid_q   <= valid_d;
            rec_q     <= rec_d;
        end
    end

`ifdef MAZE_TIMEOUT_EN
    // Timeout flag register: describes how the most recent run ended.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q <= 1'b0;
        end else begin
            to_q <= to_d;
        end
    end

    assign bus.timed_out = to_q;
`else
    assign bus.timed_out = 1'b0;
`endif

    assign bus.state      = state_q;
    assign bus.elapsed    = elapsed_q;
    assign bus.last_time  = last_q;
    assign bus.best_time  = best_q;
    assign bus.best_valid = valid_q;
    assign bus.new_record = rec_q;

endmodule

// File: tb/tb_maze_run_ctrl.sv
// Testbench for maze_run_ctrl with CLK_FREQ=100, TICK_RATE=10 (tick every
// 10 cycles) and TIME_LIMIT=4. Table-driven vectors through a scoreboard
// queue, plus a hand-written asynchronous reset sequence.
module tb_maze_run_ctrl;

    logic clk;
    logic reset_n;

    maze_run_if bus();

    maze_run_ctrl #(
        .CLK_FREQ   (100),
        .TICK_RATE  (10),
        .TIME_LIMIT (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st, pa, go, cl;
        int          hold;
        logic [1:0]  e_state;
        logic [15:0] e_el, e_last, e_best;
        logic        e_valid, e_rec, e_to;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   split;

    function automatic void add(string name, logic st, logic pa, logic go, logic cl,
                                int hold, logic [1:0] es, logic [15:0] eel,
                                logic [15:0] elast, logic [15:0] ebest,
                                logic ev, logic er, logic eto);
        vec_t v;
        v.name = name; v.st = st; v.pa = pa; v.go = go; v.cl = cl; v.hold = hold;
        v.e_state = es; v.e_el = eel; v.e_last = elast; v.e_best = ebest;
        v.e_valid = ev; v.e_rec = er; v.e_to = eto;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, string field, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
        end
    endtask

    task automatic chk_all(vec_t e);
        chk(e.name, "state",      16'(bus.state),      16'(e.e_state));
        chk(e.name, "elapsed",    bus.elapsed,         e.e_el);
        chk(e.name, "last_time",  bus.last_time,       e.e_last);
        chk(e.name, "best_time",  bus.best_time,       e.e_best);
        chk(e.name, "best_valid", 16'(bus.best_valid), 16'(e.e_valid));
        chk(e.name, "new_record", 16'(bus.new_record), 16'(e.e_rec));
        chk(e.name, "timed_out",  16'(bus.timed_out),  16'(e.e_to));
    endtask

    // Drive one vector at a negedge, let 1+hold rising edges pass, then compare.
    task automatic run_vecs(int lo, int hi);
        vec_t e;
        for (int i = lo; i < hi; i++) begin
            bus.start = vecs[i].st; bus.pause = vecs[i].pa;
            bus.goal = vecs[i].go; bus.clear_best = vecs[i].cl;
            sb.push_back(vecs[i]);
            @(negedge clk);
            bus.start = 1'b0; bus.pause = 1'b0; bus.goal = 1'b0; bus.clear_best = 1'b0;
            repeat (vecs[i].hold) @(negedge clk);
            e = sb.pop_front();
            chk_all(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rst_exp;

        // Test 1: first run sets the best time
        add("t1_start", 1,0,0,0,  0, 2'd1, 16'd0, 16'd0, 16'hFFFF, 0,0,0);
        add("t1_run",   0,0,0,0, 34, 2'd1, 16'd3, 16'd0, 16'hFFFF, 0,0,0);
        add("t1_goal",  0,0,1,0,  0, 2'd3, 16'd3, 16'd3, 16'd3,    1,1,0);
        add("t1_pulse", 0,0,0,0,  0, 2'd3, 16'd3, 16'd3, 16'd3,    1,0,0);
        // Test 2: pause freezes elapsed, equal time is not a record
        add("t2_start", 1,0,0,0,  0, 2'd1, 16'd0, 16'd3, 16'd3,    1,0,0);
        add("t2_run",   0,0,0,0, 19, 2'd1, 16'd2, 16'd3, 16'd3,    1,0,0);
        add("t2_pause", 0,1,0,0,  0, 2'd2, 16'd2, 16'd3, 16'd3,    1,0,0);
        add("t2_held",  0,0,0,0, 49, 2'd2, 16'd2, 16'd3, 16'd3,    1,0,0);
        add("t2_resume",0,1,0,0,  0, 2'd1, 16'd2, 16'd3, 16'd3,    1,0,0);
        add("t2_run2",  0,0,0,0, 14, 2'd1, 16'd3, 16'd3, 16'd3,    1,0,0);
        add("t2_goal",  0,0,1,0,  0, 2'd3, 16'd3, 16'd3, 16'd3,    1,0,0);
        // Test 3: faster run is a record, then clear_best
        add("t3_start", 1,0,0,0,  0, 2'd1, 16'd0, 16'd3, 16'd3,    1,0,0);
        add("t3_run",   0,0,0,0, 11, 2'd1, 16'd1, 16'd3, 16'd3,    1,0,0);
        add("t3_goal",  0,0,1,0,  0, 2'd3, 16'd1, 16'd1, 16'd1,    1,1,0);
        add("t3_clear", 0,0,0,1,  0, 2'd3, 16'd1, 16'd1, 16'hFFFF, 0,0,0);
        // Test 4: simultaneous pulses
        add("t4_start", 1,0,0,0,  0, 2'd1, 16'd0, 16'd1, 16'hFFFF, 0,0,0);
        add("t4_run",   0,0,0,0, 11, 2'd1, 16'd1, 16'd1, 16'hFFFF, 0,0,0);
        add("t4_goalclr",0,0,1,1, 0, 2'd3, 16'd1, 16'd1, 16'hFFFF, 0,0,0);
        add("t4_start2",1,0,0,0,  0, 2'd1, 16'd0, 16'd1, 16'hFFFF, 0,0,0);
        add("t4_run2",  0,0,0,0,  4, 2'd1, 16'd0, 16'd1, 16'hFFFF, 0,0,0);
        add("t4_goalpau",0,1,1,0, 0, 2'd3, 16'd0, 16'd0, 16'd0,    1,1,0);
        add("t4_stpause",1,1,0,0, 0, 2'd1, 16'd0, 16'd0, 16'd0,    1,0,0);
        add("t4_run3",  0,0,0,0, 11, 2'd1, 16'd1, 16'd0, 16'd0,    1,0,0);
        split = vecs.size();
        // Test 5 tail: pulses ignored in IDLE after reset
        add("t5_goal",  0,0,1,0,  0, 2'd0, 16'd0, 16'd0, 16'hFFFF, 0,0,0);
        add("t5_pause", 0,1,0,0,  2, 2'd0, 16'd0, 16'd0, 16'hFFFF, 0,0,0);
        // Test 6: run limit
        add("t6_start", 1,0,0,0,  0, 2'd1, 16'd0, 16'd0, 16'hFFFF, 0,0,0);
`ifdef MAZE_TIMEOUT_EN
        add("t6_limit", 0,0,0,0, 59, 2'd3, 16'd4, 16'd4, 16'hFFFF, 0,0,1);
        add("t6_restart",1,0,0,0, 0, 2'd1, 16'd0, 16'd4, 16'hFFFF, 0,0,1);
`else
        add("t6_nolimit",0,0,0,0, 59, 2'd1, 16'd6, 16'd0, 16'hFFFF, 0,0,0);
`endif

        rst_exp.e_state = 2'd0; rst_exp.e_el = 16'd0; rst_exp.e_last = 16'd0;
        rst_exp.e_best = 16'hFFFF; rst_exp.e_valid = 1'b0; rst_exp.e_rec = 1'b0;
        rst_exp.e_to = 1'b0;

        bus.start = 1'b0; bus.pause = 1'b0; bus.goal = 1'b0; bus.clear_best = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rst_exp.name = "reset";
        chk_all(rst_exp);

        run_vecs(0, split);

        // Test 5: asynchronous reset between clock edges while RUNNING
        #2;
        reset_n = 1'b0;
        #1;
        rst_exp.name = "async_reset";
        chk_all(rst_exp);
        @(negedge clk);
        reset_n = 1'b1;

        run_vecs(split, vecs.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
